pi_current_ctrl: RTL and testbench
==================================

Name: pi_current_ctrl

Overview:
- Dual-axis PI current controller that sits directly downstream of the Park transform.
- Consumes measured Id/Iq and the transform's done pulse; produces voltage commands Vd/Vq for the inverse-Park stage.
- A single shared multiplier is time-multiplexed by an FSM, so each update completes with a fixed 7-cycle latency.

Parameters:
- FRAC, 10, fractional bits of iKp/iKi (gain 1.0 = 2^FRAC)
- INT_LIM, 2047, integrator clamp magnitude (symmetric ±INT_LIM)
- OUT_LIM, 2047, output saturation magnitude (symmetric ±OUT_LIM, ≤2047)

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iPi_en  in  1  start; rising edge triggers one update (typically Park oP_done)
- iInt_clr  in  1  synchronous integrator clear / abort
- iId_ref, iIq_ref  in  12 signed  current references
- iId, iIq  in  12 signed  measured currents
- iKp, iKi  in  16 unsigned  gains, Q(16-FRAC).FRAC
- oVd, oVq  out  12 signed  voltage commands
- oPi_done  out  1  one-cycle pulse when oVd/oVq are updated
- oBusy  out  1  high while FSM not IDLE

Behaviour:
- Reset (async): oVd=0, oVq=0, oPi_done=0, both integrators=0, edge-detect register=0, FSM=IDLE.
- Edge detect: register iPi_en each cycle. Trigger = iPi_en & !prev, sampled at edge k.
- FSM (one state per cycle): IDLE → DP → DI → DU → QP → QI → QU → OUT → IDLE.
  - Edge k (IDLE, trigger): capture refs, measurements and gains. err_d = iId_ref - iId, err_q = iIq_ref - iIq (13-bit signed, no wrap). Go to DP.
  - DP: p_d = (err_d*iKp) >>> FRAC.
  - DI: i_d = (err_d*iKi) >>> FRAC.
  - DU: cand_d = clamp(integ_d + i_d, ±INT_LIM); sum_d = p_d + cand_d; vd_n = sat(sum_d, ±OUT_LIM); commit integ_d = cand_d.
  - QP, QI, QU: identical steps for the q axis.
  - OUT: oVd ← vd_n, oVq ← vq_n, oPi_done = 1. This is edge k+7.
- oPi_done is high exactly one cycle. Outputs hold their values between updates.
- Internal widths: product 29 bits; sums ≥21 bits. No intermediate wrap is permitted.
- oBusy = (state != IDLE). A trigger detected while busy, including at edge k+7, is ignored and not queued.
- iInt_clr (highest priority, any state): integ_d = integ_q = 0; FSM → IDLE. Any in-flight update is discarded with no oPi_done; oVd/oVq hold. If iInt_clr and a trigger arrive together, the clear wins and the trigger is dropped.
- Captured inputs are frozen during an update; input changes after edge k have no effect until the next trigger.
- Reset asserted mid-update: immediate return to reset values.

Optional Feature:
- Macro PI_ANTIWINDUP_EN.
- Defined: in DU/QU, if sum > OUT_LIM with err > 0, or sum < -OUT_LIM with err < 0, the integrator is NOT committed and keeps its old value. The output is still sat(p + cand).
- Undefined: the integrator always commits cand; only the ±INT_LIM clamp applies.

Test Plan:
- Reset: hold iRst_n=0 with random inputs → oVd=oVq=0, oPi_done=0, oBusy=0. Release, no trigger → outputs stay 0.
- P only: iKp=1024, iKi=0, iId_ref=100, iId=40, iIq_ref=-50, iIq=0, pulse iPi_en at edge k → at edge k+7 oVd=60, oVq=-50, oPi_done high one cycle; oBusy high edges k..k+6.
- I accumulation: iKp=0, iKi=512, err_d=100, three triggers → oVd=50, 100, 150. Then iInt_clr pulse and one more trigger → oVd=50.
- Saturation: iKp=65535, iKi=0, err_d=+2000 → oVd=2047; err_d=-2000 → oVd=-2047.
- Anti-windup: iKp=1024, iKi=1024, err_d=1000 for two triggers, then err_d=-500 for one trigger → oVd = 2000, 2047, then 0 with PI_ANTIWINDUP_EN defined, or 1000 without it.
- Busy/abort:
  - Second iPi_en rising edge at edge k+3 → ignored; exactly one oPi_done at k+7.
  - iInt_clr at edge k+4 → no oPi_done, outputs unchanged, oBusy low from edge k+4.

Source files
------------

// File: rtl/pi_current_ctrl.sv
// Dual-axis (d/q) PI current controller fed by the Park transform.
// One shared multiplier is sequenced by an FSM; each update takes 7 cycles
// from the iPi_en rising edge to the oPi_done pulse.
// Optional build macro: PI_ANTIWINDUP_EN. When it is defined, an axis whose
// output saturates in the direction of its error keeps its integrator value.
module pi_current_ctrl #(
    parameter int unsigned FRAC    = 10,
    parameter int unsigned INT_LIM = 2047,
    parameter int unsigned OUT_LIM = 2047
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iPi_en,
    input  logic               iInt_clr,
    input  logic signed [11:0] iId_ref,
    input  logic signed [11:0] iIq_ref,
    input  logic signed [11:0] iId,
    input  logic signed [11:0] iIq,
    input  logic        [15:0] iKp,
    input  logic        [15:0] iKi,
    output logic signed [11:0] oVd,
    output logic signed [11:0] oVq,
    output logic               oPi_done,
    output logic               oBusy
);

    typedef enum logic [2:0] {
        StIdle, StDp, StDi, StDu, StQp, StQi, StQu, StOut
    } state_e;

    localparam logic signed [31:0] IntMax   = 32'(INT_LIM);
    localparam logic signed [31:0] OutMax   = 32'(OUT_LIM);
    localparam logic signed [11:0] OutMax12 = 12'(OUT_LIM);

    state_e             state_q, state_d;
    logic               pi_en_q;
    logic               trigger;
    logic signed [12:0] err_d_q, err_q_q;
    logic        [15:0] kp_q, ki_q;
    logic signed [31:0] p_q, i_q;
    logic signed [31:0] integ_d_q, integ_q_q;
    logic signed [11:0] vd_n_q, vq_n_q;

    logic               is_q;
    logic signed [12:0] err_axis;
    logic        [15:0] mul_gain;
    logic signed [29:0] product, scaled;
    logic signed [31:0] integ_sel, cand, sum;
    logic signed [11:0] sat_val;
    logic               commit;

    assign trigger = iPi_en & ~pi_en_q;
    assign oBusy   = (state_q != StIdle);

    // Operand selection for the shared multiplier and the update stage
    assign is_q     = (state_q == StQp) || (state_q == StQi) || (state_q == StQu);
    assign err_axis = is_q ? err_q_q : err_d_q;
    assign mul_gain = ((state_q == StDp) || (state_q == StQp)) ? kp_q : ki_q;
    // Gain is unsigned, so zero-extend before the signed multiply
    assign product  = 30'(err_axis) * 30'($signed({1'b0, mul_gain}));
    assign scaled   = product >>> FRAC;

    // Integrator clamp, output saturation and integrator commit decision
    always_comb begin
        integ_sel = is_q ? integ_q_q : integ_d_q;
        cand      = integ_sel + i_q;
        if (cand > IntMax) begin
            cand = IntMax;
        end else if (cand < -IntMax) begin
            cand = -IntMax;
        end
        sum     = p_q + cand;
        sat_val = sum[11:0];
        if (sum > OutMax) begin
            sat_val = OutMax12;
        end else if (sum < -OutMax) begin
            sat_val = -OutMax12;
        end
        commit = 1'b1;
`ifdef PI_ANTIWINDUP_EN
        if ((sum > OutMax && err_axis > 13'sd0) || (sum < -OutMax && err_axis < 13'sd0)) begin
            commit = 1'b0;
        end
`endif
    end

    // Next-state sequencing; a clear always forces the FSM back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (trigger) state_d = StDp;
            StDp:    state_d = StDi;
            StDi:    state_d = StDu;
            StDu:    state_d = StQp;
            StQp:    state_d = StQi;
            StQi:    state_d = StQu;
            StQu:    state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (iInt_clr) begin
            state_d = StIdle;
        end
    end

    // State register and enable edge detector
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
            pi_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pi_en_q <= iPi_en;
        end
    end

    // Datapath: capture, product terms, integrators and output registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            err_d_q   <= '0;
            err_q_q   <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            p_q       <= '0;
            i_q       <= '0;
            integ_d_q <= '0;
            integ_q_q <= '0;
            vd_n_q    <= '0;
            vq_n_q    <= '0;
            oVd       <= '0;
            oVq       <= '0;
            oPi_done  <= 1'b0;
        end else if (iInt_clr) begin
            // Abort: integrators zeroed, outputs hold, no done pulse
            integ_d_q <= '0;
            integ_q_q <= '0;
            oPi_done  <= 1'b0;
        end else begin
            oPi_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        err_d_q <= 13'(iId_ref) - 13'(iId);
                        err_q_q <= 13'(iIq_ref) - 13'(iIq);
                        kp_q    <= iKp;
                        ki_q    <= iKi;
                    end
                end
                StDp, StQp: p_q <= 32'(scaled);
                StDi, StQi: i_q <= 32'(scaled);
                StDu: begin
                    vd_n_q <= sat_val;
                    if (commit) integ_d_q <= cand;
                end
                StQu: begin
                    vq_n_q <= sat_val;
                    if (commit) integ_q_q <= cand;
                end
                StOut: begin
                    oVd      <= vd_n_q;
                    oVq      <= vq_n_q;
                    oPi_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pi_current_ctrl.sv
// Self-checking bench for pi_current_ctrl: directed cases plus random updates,
// expected Vd/Vq pushed to a queue at trigger time, popped by a done monitor.
module tb_pi_current_ctrl;

    localparam int    FRAC = 10;
    localparam longint ILIM = 2047;
    localparam longint OLIM = 2047;

    typedef struct {
        int vd;
        int vq;
    } exp_t;

    logic               iClk = 1'b0;
    logic               iRst_n;
    logic               iPi_en;
    logic               iInt_clr;
    logic signed [11:0] iId_ref, iIq_ref, iId, iIq;
    logic        [15:0] iKp, iKi;
    logic signed [11:0] oVd, oVq;
    logic               oPi_done;
    logic               oBusy;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    int   m_integ_d = 0;
    int   m_integ_q = 0;
    int   last_vd = 0;
    int   last_vq = 0;

    pi_current_ctrl #(
        .FRAC   (10),
        .INT_LIM(2047),
        .OUT_LIM(2047)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iPi_en  (iPi_en),
        .iInt_clr(iInt_clr),
        .iId_ref (iId_ref),
        .iIq_ref (iIq_ref),
        .iId     (iId),
        .iIq     (iIq),
        .iKp     (iKp),
        .iKi     (iKi),
        .oVd     (oVd),
        .oVq     (oVq),
        .oPi_done(oPi_done),
        .oBusy   (oBusy)
    );

    always #5 iClk = ~iClk;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference for one axis: floor-scaled products, clamp, saturate
    task automatic model_axis(input int err, input int kp, input int ki,
                              inout int integ, output int v);
        longint p, i, cand, sum;
        p    = (longint'(err) * kp) >>> FRAC;
        i    = (longint'(err) * ki) >>> FRAC;
        cand = integ + i;
        if (cand > ILIM) cand = ILIM;
        if (cand < -ILIM) cand = -ILIM;
        sum = p + cand;
        v   = int'((sum > OLIM) ? OLIM : ((sum < -OLIM) ? -OLIM : sum));
`ifdef PI_ANTIWINDUP_EN
        if (!((sum > OLIM && err > 0) || (sum < -OLIM && err < 0))) integ = int'(cand);
`else
        integ = int'(cand);
`endif
    endtask

    task automatic randomize_inputs();
        iId_ref = 12'($urandom_range(0, 4095));
        iIq_ref = 12'($urandom_range(0, 4095));
        iId     = 12'($urandom_range(0, 4095));
        iIq     = 12'($urandom_range(0, 4095));
        iKp     = 16'($urandom);
        iKi     = 16'($urandom);
    endtask

    // Called just after a rising edge; issues a trigger at the next edge (edge k)
    task automatic start(input int idr, input int id, input int iqr, input int iq,
                         input int kp, input int ki, input bit push);
        exp_t e;
        iId_ref = 12'(idr);
        iId     = 12'(id);
        iIq_ref = 12'(iqr);
        iIq     = 12'(iq);
        iKp     = 16'(kp);
        iKi     = 16'(ki);
        if (push) begin
            model_axis(idr - id, kp, ki, m_integ_d, e.vd);
            model_axis(iqr - iq, kp, ki, m_integ_q, e.vq);
            exp_q.push_back(e);
            last_vd = e.vd;
            last_vq = e.vq;
        end
        iPi_en = 1'b1;
        @(posedge iClk);
        #1;
        iPi_en = 1'b0;
        chk("busy_after_trigger", int'(oBusy), 1);
    endtask

    // Wait (bounded) until the update ends; optionally scramble inputs meanwhile
    task automatic wait_done(input bit scramble);
        int n;
        n = 0;
        while (oBusy && n < 20) begin
            if (scramble) randomize_inputs();
            @(posedge iClk);
            #1;
            n++;
        end
        if (oBusy) chk("busy_timeout", int'(oBusy), 0);
        @(posedge iClk);
        #1;
    endtask

    task automatic clr_pulse();
        iInt_clr = 1'b1;
        @(posedge iClk);
        #1;
        iInt_clr = 1'b0;
        m_integ_d = 0;
        m_integ_q = 0;
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge iClk) begin
        if (iRst_n && oPi_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("vd", int'(oVd), e.vd);
                chk("vq", int'(oVq), e.vq);
                chk("busy_at_done", int'(oBusy), 0);
            end
        end
    end

    initial begin
        int base;
        iRst_n   = 1'b0;
        iInt_clr = 1'b0;
        iPi_en   = 1'b0;
        randomize_inputs();

        // Reset with random inputs
        for (int c = 0; c < 5; c++) begin
            @(posedge iClk);
            #1;
            randomize_inputs();
            iPi_en   = 1'($urandom);
            iInt_clr = 1'($urandom);
            chk("rst_vd", int'(oVd), 0);
            chk("rst_vq", int'(oVq), 0);
            chk("rst_done", int'(oPi_done), 0);
            chk("rst_busy", int'(oBusy), 0);
        end
        iPi_en   = 1'b0;
        iInt_clr = 1'b0;
        iRst_n   = 1'b1;
        repeat (5) @(posedge iClk);
        #1;
        chk("idle_vd", int'(oVd), 0);
        chk("idle_vq", int'(oVq), 0);
        chk("idle_busy", int'(oBusy), 0);

        // P only, with busy trace over edges k..k+7
        start(100, 40, -50, 0, 1024, 0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(posedge iClk);
            #1;
            chk("p_busy", int'(oBusy), 1);
            chk("p_no_done_early", int'(oPi_done), 0);
        end
        @(posedge iClk);
        #1;
        chk("p_done_k7", int'(oPi_done), 1);
        chk("p_busy_k7", int'(oBusy), 0);
        @(posedge iClk);
        #1;
        chk("p_done_one_cycle", int'(oPi_done), 0);

        // Integrator accumulation, then clear
        clr_pulse();
        for (int t = 0; t < 3; t++) begin
            start(100, 0, 0, 0, 0, 512, 1'b1);
            wait_done(1'b0);
        end
        clr_pulse();
        start(100, 0, 0, 0, 0, 512, 1'b1);
        wait_done(1'b0);

        // Saturation both ways
        clr_pulse();
        start(1000, -1000, 0, 0, 65535, 0, 1'b1);
        wait_done(1'b0);
        start(-1000, 1000, 0, 0, 65535, 0, 1'b1);
        wait_done(1'b0);

        // Anti-windup sequence
        clr_pulse();
        start(1000, 0, 0, 0, 1024, 1024, 1'b1);
        wait_done(1'b0);
        start(1000, 0, 0, 0, 1024, 1024, 1'b1);
        wait_done(1'b0);
        start(-500, 0, 0, 0, 1024, 1024, 1'b1);
        wait_done(1'b0);

        // Retriggers at k+3 and k+7 are ignored
        base = done_cnt;
        start(300, 100, 200, 50, 2048, 300, 1'b1);
        repeat (2) @(posedge iClk);
        #1;
        iPi_en = 1'b1;                      // rising at k+3
        @(posedge iClk);
        #1;
        iPi_en = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        iPi_en = 1'b1;                      // rising at k+7
        @(posedge iClk);
        #1;
        chk("retrig_done_k7", int'(oPi_done), 1);
        repeat (3) @(posedge iClk);
        #1;
        iPi_en = 1'b0;
        repeat (10) @(posedge iClk);
        #1;
        chk("retrig_done_count", done_cnt - base, 1);
        chk("retrig_busy", int'(oBusy), 0);

        // Abort with iInt_clr at k+4
        base = done_cnt;
        start(-700, 200, 900, -300, 1500, 800, 1'b0);
        repeat (3) @(posedge iClk);
        #1;
        iInt_clr = 1'b1;
        @(posedge iClk);
        #1;
        iInt_clr  = 1'b0;
        m_integ_d = 0;
        m_integ_q = 0;
        chk("abort_busy", int'(oBusy), 0);
        repeat (10) @(posedge iClk);
        #1;
        chk("abort_no_done", done_cnt - base, 0);
        chk("abort_vd_hold", int'(oVd), last_vd);
        chk("abort_vq_hold", int'(oVq), last_vq);

        // Clear and trigger together: trigger dropped
        iInt_clr = 1'b1;
        iPi_en   = 1'b1;
        @(posedge iClk);
        #1;
        iInt_clr = 1'b0;
        iPi_en   = 1'b0;
        chk("clr_vs_trig_busy", int'(oBusy), 0);
        repeat (10) @(posedge iClk);
        #1;
        chk("clr_vs_trig_no_done", done_cnt - base, 0);

        // Reset mid-update
        start(500, 0, -500, 0, 1024, 0, 1'b0);
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        chk("midrst_vd", int'(oVd), 0);
        chk("midrst_busy", int'(oBusy), 0);
        @(posedge iClk);
        #1;
        iRst_n    = 1'b1;
        m_integ_d = 0;
        m_integ_q = 0;
        last_vd   = 0;
        last_vq   = 0;
        @(posedge iClk);
        #1;

        // Random updates with inputs changing while busy
        for (int t = 0; t < 40; t++) begin
            int kp, ki;
            if ($urandom_range(0, 7) == 0) clr_pulse();
            kp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 2048));
            ki = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 1024));
            start(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                  int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                  kp, ki, 1'b1);
            wait_done(1'b1);
            repeat ($urandom_range(0, 3)) @(posedge iClk);
            #1;
        end

        repeat (5) @(posedge iClk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
